// File: rtl/alu_seq_ysyx_pkg.sv
// alu_seq_ysyx_pkg: ALU control codes, operand-select codes, M-op codes and sequencer states
package alu_seq_ysyx_pkg;
  localparam int XLEN  = 32;
  localparam int NITER = 32;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_LUI  = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SLTU = 4'b1010,
    ALU_SRA  = 4'b1101
  } alu_ctr_e;
  localparam logic [1:0] BSRC_RS2  = 2'b00;
  localparam logic [1:0] BSRC_IMM  = 2'b01;
  localparam logic [1:0] BSRC_FOUR = 2'b10;
  localparam logic [4:0] OP_MUL  = 5'h10;
  localparam logic [4:0] OP_DIVU = 5'h11;
  localparam logic [4:0] OP_REMU = 5'h12;
  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MUL, S_DIV, S_DONE} state_e;
endpackage

// File: rtl/alu_seq_ysyx_if.sv
// alu_seq_ysyx_if: request and result valid/ready channels between decode, sequencer and WBU
interface alu_seq_ysyx_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_op;
  logic [31:0] in_pc;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [31:0] in_imm;
  logic        in_asrc;
  logic [1:0]  in_bsrc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_less;
  logic        out_zero;
  modport master (
    output in_valid, in_op, in_pc, in_rs1, in_rs2, in_imm, in_asrc, in_bsrc, out_ready,
    input  in_ready, out_valid, out_result, out_less, out_zero
  );
  modport slave (
    input  in_valid, in_op, in_pc, in_rs1, in_rs2, in_imm, in_asrc, in_bsrc, out_ready,
    output in_ready, out_valid, out_result, out_less, out_zero
  );
endinterface

// File: rtl/ALU_ysyx.sv
// ALU_ysyx: combinational ALU; SLT/SLTU return the difference on result and the compare on less
module ALU_ysyx
  import alu_seq_ysyx_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic [31:0] imm_i,
  input  logic [3:0]  ctr_i,
  input  logic        asrc_i,
  input  logic [1:0]  bsrc_i,
  output logic [31:0] result_o,
  output logic        less_o,
  output logic        zero_o
);
  logic [31:0] a, b, diff;
  assign a = asrc_i ? pc_i : rs1_i;
  assign b = bsrc_i == BSRC_RS2 ? rs2_i : bsrc_i == BSRC_IMM ? imm_i : bsrc_i == BSRC_FOUR ? 32'd4 : 32'd0;
  assign diff = a - b;
  assign zero_o = result_o == 32'd0;
  always_comb begin
    less_o = ctr_i == ALU_SLTU ? a < b : ctr_i == ALU_SLT ? $signed(a) < $signed(b) : 1'b0;
    case (ctr_i)
      ALU_ADD:           result_o = a + b;
      ALU_SUB, ALU_SLT,
      ALU_SLTU:          result_o = diff;
      ALU_LUI:           result_o = b;
      ALU_XOR:           result_o = a ^ b;
      ALU_OR:            result_o = a | b;
      ALU_AND:           result_o = a & b;
      ALU_SLL:           result_o = a << b[4:0];
      ALU_SRL:           result_o = a >> b[4:0];
      ALU_SRA:           result_o = $signed(a) >>> b[4:0];
      default:           result_o = 32'd0;
    endcase
  end
endmodule

// File: rtl/alu_seq_ysyx.sv
// alu_seq_ysyx: execute-stage sequencer; single-pass ALU ops, iterative MUL/DIVU/REMU on the shared ALU
module alu_seq_ysyx
  import alu_seq_ysyx_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  alu_seq_ysyx_if.slave bus,
  output logic [31:0]  alu_pc_o,
  output logic [31:0]  alu_rs1_o,
  output logic [31:0]  alu_rs2_o,
  output logic [31:0]  alu_imm_o,
  output logic [3:0]   alu_ctr_o,
  output logic         alu_asrc_o,
  output logic [1:0]   alu_bsrc_o,
  input  logic [31:0]  alu_result_i,
  input  logic         alu_less_i,
  input  logic         alu_zero_i
);
  state_e      state_q;
  logic [4:0]  op_q, cnt_q;
  logic [31:0] pc_q, rs1_q, rs2_q, imm_q, acc_q;
  logic        asrc_q;
  logic [1:0]  bsrc_q;
  logic        out_valid_q, out_less_q, out_zero_q;
  logic [31:0] out_result_q;
  logic [31:0] sh, rem_d, quo_d, short_res;
  logic        take, last, st_exec, st_mul, st_div;
  assign st_exec = state_q == S_EXEC;
  assign st_mul  = state_q == S_MUL;
  assign st_div  = state_q == S_DIV;
  assign last    = cnt_q == 5'(NITER - 1);
  // DIV keeps the remainder in acc_q and shifts the quotient through rs1_q
  assign sh    = {acc_q[30:0], rs1_q[31]};
  assign take  = acc_q[31] | ~alu_less_i;
  assign rem_d = take ? alu_result_i : sh;
  assign quo_d = {rs1_q[30:0], take};
  assign short_res = bus.in_op == OP_DIVU ? 32'hFFFF_FFFF : bus.in_op == OP_REMU ? bus.in_rs1 : 32'd0;
  assign bus.in_ready   = state_q == S_IDLE;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_less   = out_less_q;
  assign bus.out_zero   = out_zero_q;
  always_comb begin
    alu_pc_o   = st_exec ? pc_q : 32'd0;
    alu_imm_o  = st_exec ? imm_q : 32'd0;
    alu_asrc_o = st_exec ? asrc_q : 1'b0;
    alu_bsrc_o = st_exec ? bsrc_q : BSRC_RS2;
    alu_ctr_o  = st_exec ? op_q[3:0] : st_div ? ALU_SLTU : ALU_ADD;
    alu_rs1_o  = st_exec ? rs1_q : st_mul ? acc_q : st_div ? sh : 32'd0;
    alu_rs2_o  = st_exec ? rs2_q : st_mul ? (rs2_q[0] ? rs1_q : 32'd0) : st_div ? rs2_q : 32'd0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      cnt_q        <= '0;
      pc_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      imm_q        <= '0;
      acc_q        <= '0;
      asrc_q       <= 1'b0;
      bsrc_q       <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_less_q   <= 1'b0;
      out_zero_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.in_valid) begin
          op_q   <= bus.in_op;
          pc_q   <= bus.in_pc;
          rs1_q  <= bus.in_rs1;
          rs2_q  <= bus.in_rs2;
          imm_q  <= bus.in_imm;
          asrc_q <= bus.in_asrc;
          bsrc_q <= bus.in_bsrc;
          acc_q  <= '0;
          cnt_q  <= '0;
          if (!bus.in_op[4]) state_q <= S_EXEC;
          else if (bus.in_op == OP_MUL) state_q <= S_MUL;
          else if ((bus.in_op == OP_DIVU || bus.in_op == OP_REMU) && bus.in_rs2 != 32'd0) state_q <= S_DIV;
          else begin
            state_q      <= S_DONE;
            out_valid_q  <= 1'b1;
            out_result_q <= short_res;
            out_less_q   <= 1'b0;
            out_zero_q   <= short_res == 32'd0;
          end
        end
        S_EXEC: begin
          state_q      <= S_DONE;
          out_valid_q  <= 1'b1;
          out_result_q <= alu_result_i;
          out_less_q   <= alu_less_i;
          out_zero_q   <= alu_zero_i;
        end
        S_MUL: begin
          acc_q <= alu_result_i;
          rs1_q <= rs1_q << 1;
          rs2_q <= rs2_q >> 1;
          cnt_q <= cnt_q + 5'd1;
          if (last) begin
            state_q      <= S_DONE;
            out_valid_q  <= 1'b1;
            out_result_q <= alu_result_i;
            out_less_q   <= 1'b0;
            out_zero_q   <= alu_result_i == 32'd0;
          end
        end
        S_DIV: begin
          acc_q <= rem_d;
          rs1_q <= quo_d;
          cnt_q <= cnt_q + 5'd1;
          if (last) begin
            state_q      <= S_DONE;
            out_valid_q  <= 1'b1;
            out_result_q <= op_q == OP_DIVU ? quo_d : rem_d;
            out_less_q   <= 1'b0;
            out_zero_q   <= (op_q == OP_DIVU ? quo_d : rem_d) == 32'd0;
          end
        end
        S_DONE: if (bus.out_ready) begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule
